// File: rtl/dmi_resp_collector.sv
// Purpose: tracks one outstanding DMI request, collects its response, keeps sticky DTM status and the Capture-DR word.
// Latency: request accept is combinational; state, status, timeout pulse and capture word update one cycle later.
// Backpressure: never stalls the debug module (response ready tied high); requests are refused while busy or in error.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   req_issue_i/op/addr   request dispatch pulse, DTM op and address; req_accept_o flags acceptance
//   dmi_resp_*            response handshake from the debug module (data, 2-bit code)
//   capture_dr_i          JTAG Capture-DR pulse; latches {addr, data, status} into dr_capture_o
//   dmireset_i            clears sticky status
//   dmihardreset_i        aborts the outstanding transaction
//   pending_o             high while waiting on a response
//   sticky_err_o          sticky status (0 none, 2 failed, 3 busy)
//   timeout_o             one-cycle pulse when a request is abandoned
module dmi_resp_collector #(
  parameter int TIMEOUT = 200,
  parameter int ABITS   = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_issue_i,
  input  logic [1:0]       req_op_i,
  input  logic [ABITS-1:0] req_addr_i,
  output logic             req_accept_o,
  input  logic             dmi_resp_valid_i,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_resp_i,
  output logic             dmi_resp_ready_o,
  input  logic             capture_dr_i,
  input  logic             dmireset_i,
  input  logic             dmihardreset_i,
  output logic [ABITS+33:0] dr_capture_o,
  output logic             pending_o,
  output logic [1:0]       sticky_err_o,
  output logic             timeout_o
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // Last counter value before the request is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [ABITS-1:0]   addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [1:0]         sticky_q, sticky_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic [ABITS+33:0]  cap_q, cap_d;

  logic in_wait;
  logic accept;
  logic resp_hit;
  logic expire;
  logic busy_evt;
  logic [1:0] err_new;

  // Event decode shared by FSM and datapath.
  always_comb begin
    in_wait  = (state_q == S_WAIT);
    accept   = req_issue_i && !in_wait && (sticky_q == 2'd0) &&
               (req_op_i != 2'd0) && !dmihardreset_i;
    resp_hit = in_wait && dmi_resp_valid_i;
    // A response in the final cycle wins over expiry.
    expire   = in_wait && !dmi_resp_valid_i && (cnt_q == CNT_LAST);
    // Busy: a new issue while outstanding, or the host scanning before the response arrived.
    busy_evt = in_wait && (req_issue_i || (capture_dr_i && !dmi_resp_valid_i));
  end

  // FSM: state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: if (resp_hit || expire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (dmihardreset_i) state_d = S_IDLE;
  end

  // FSM: outputs.
  always_comb begin
    pending_o        = (state_q == S_WAIT);
    req_accept_o     = accept;
    dmi_resp_ready_o = 1'b1;
  end

  // Datapath next values. The capture word is built from these post-update
  // values so a capture coinciding with a response reports the new data.
  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    err_new   = 2'd0;

    if (accept) begin
      addr_d = req_addr_i;
      cnt_d  = 8'd0;
    end

    if (resp_hit) begin
      data_d = dmi_resp_data_i;
      cnt_d  = 8'd0;
    end else if (expire) begin
      cnt_d     = 8'd0;
      timeout_d = 1'b1;
    end else if (in_wait) begin
      cnt_d = cnt_q + 8'd1;
    end

    // Only the first error since the last dmireset is kept.
    if (resp_hit && dmi_resp_resp_i != 2'd0) err_new = dmi_resp_resp_i;
    else if (busy_evt)                       err_new = 2'd3;
    else if (expire)                         err_new = 2'd2;
    if (sticky_q == 2'd0) sticky_d = err_new;

    if (dmireset_i) sticky_d = 2'd0;

    if (dmihardreset_i) begin
      sticky_d  = 2'd0;
      data_d    = 32'd0;
      cnt_d     = 8'd0;
      timeout_d = 1'b0;
    end

    cap_d = cap_q;
    if (capture_dr_i) cap_d = {addr_d, data_d, sticky_d};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      data_q    <= '0;
      sticky_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      cap_q     <= '0;
    end else begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      cap_q     <= cap_d;
    end
  end

  assign sticky_err_o = sticky_q;
  assign timeout_o    = timeout_q;
  assign dr_capture_o = cap_q;

endmodule

// File: tb/tb_dmi_resp_collector.sv
module tb_dmi_resp_collector;

  localparam int TO = 4;
  localparam int AB = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_issue = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [AB-1:0] req_addr = '0;
  logic        req_accept;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'd0;
  logic [1:0]  resp_code = 2'd0;
  logic        resp_ready;
  logic        capture_dr = 1'b0;
  logic        dmireset = 1'b0;
  logic        dmihardreset = 1'b0;
  logic [AB+33:0] dr_capture;
  logic        pending;
  logic [1:0]  sticky;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  dmi_resp_collector #(.TIMEOUT(TO), .ABITS(AB)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_issue_i(req_issue), .req_op_i(req_op), .req_addr_i(req_addr),
    .req_accept_o(req_accept),
    .dmi_resp_valid_i(resp_valid), .dmi_resp_data_i(resp_data),
    .dmi_resp_resp_i(resp_code), .dmi_resp_ready_o(resp_ready),
    .capture_dr_i(capture_dr), .dmireset_i(dmireset), .dmihardreset_i(dmihardreset),
    .dr_capture_o(dr_capture), .pending_o(pending),
    .sticky_err_o(sticky), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, its age in wait cycles,
  // and the first error seen since the status was last cleared.
  logic          m_out = 1'b0;
  int            m_age = 0;
  logic [AB-1:0] m_addr = '0;
  logic [31:0]   m_data = '0;
  logic [1:0]    m_status = '0;
  logic [AB+33:0] m_cap = '0;
  logic          m_to = 1'b0;

  always @(posedge clk) begin : model
    logic          n_out;
    int            n_age;
    logic [AB-1:0] n_addr;
    logic [31:0]   n_data;
    logic [1:0]    n_status;
    logic [AB+33:0] n_cap;
    logic          n_to;
    logic [1:0]    err;
    n_out = m_out; n_age = m_age; n_addr = m_addr; n_data = m_data;
    n_status = m_status; n_cap = m_cap; n_to = 1'b0; err = 2'd0;
    if (rst) begin
      n_out = 1'b0; n_age = 0; n_addr = '0; n_data = '0; n_status = '0; n_cap = '0;
    end else begin
      if (dmihardreset) begin
        n_out = 1'b0; n_age = 0; n_data = '0; n_status = '0;
      end else begin
        if (!m_out) begin
          if (req_issue && m_status == 2'd0 && req_op != 2'd0) begin
            n_out = 1'b1; n_addr = req_addr; n_age = 0;
          end
        end else begin
          if (resp_valid) begin
            n_data = resp_data; n_out = 1'b0; n_age = 0;
            if (resp_code != 2'd0) err = resp_code;
          end
          if (err == 2'd0 && (req_issue || (capture_dr && !resp_valid))) err = 2'd3;
          if (!resp_valid) begin
            if (m_age + 1 >= TO) begin
              n_out = 1'b0; n_to = 1'b1; n_age = 0;
              if (err == 2'd0) err = 2'd2;
            end else begin
              n_age = m_age + 1;
            end
          end
          if (m_status == 2'd0 && err != 2'd0) n_status = err;
        end
        if (dmireset) n_status = 2'd0;
      end
      if (capture_dr) n_cap = {n_addr, n_data, n_status};
    end
    m_out <= n_out; m_age <= n_age; m_addr <= n_addr; m_data <= n_data;
    m_status <= n_status; m_cap <= n_cap; m_to <= n_to;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pending", 64'(pending), 64'(m_out));
      chk("sticky", 64'(sticky), 64'(m_status));
      chk("timeout", 64'(timeout), 64'(m_to));
      chk("dr_capture", 64'(dr_capture), 64'(m_cap));
      chk("req_accept", 64'(req_accept),
          64'(req_issue && !m_out && m_status == 2'd0 && req_op != 2'd0 && !dmihardreset));
      chk("resp_ready", 64'(resp_ready), 64'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_issue = 1'b0; req_op = 2'd0; resp_valid = 1'b0; resp_code = 2'd0;
    capture_dr = 1'b0; dmireset = 1'b0; dmihardreset = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [AB-1:0] a);
    req_issue = 1'b1; req_op = op; req_addr = a;
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] c);
    resp_valid = 1'b1; resp_data = d; resp_code = c;
  endtask

  initial begin
    int pcnt;
    int tcnt;
    int tpos;

    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_pending", 64'(pending), 64'd0);
    chk("reset_sticky", 64'(sticky), 64'd0);
    chk("reset_capture", 64'(dr_capture), 64'd0);
    chk("reset_timeout", 64'(timeout), 64'd0);

    // Basic read, response in the third wait cycle, then capture.
    issue(2'd1, 7'h11);
    #1 chk("read_accept", 64'(req_accept), 64'd1);
    pcnt = 0;
    step(); if (pending) pcnt++;
    step(); if (pending) pcnt++;
    step(); if (pending) pcnt++;
    respond(32'hDEADBEEF, 2'd0);
    step(); if (pending) pcnt++;
    chk("read_pending_cycles", 64'(pcnt), 64'd3);
    capture_dr = 1'b1;
    step();
    chk("read_capture", 64'(dr_capture), 64'({7'h11, 32'hDEADBEEF, 2'd0}));

    // Capture while waiting marks busy; accept blocked until dmireset.
    issue(2'd1, 7'h22);
    step();
    capture_dr = 1'b1;
    step();
    chk("busy_sticky", 64'(sticky), 64'd3);
    respond(32'h12345678, 2'd0);
    step();
    chk("busy_sticky_kept", 64'(sticky), 64'd3);
    chk("busy_idle", 64'(pending), 64'd0);
    issue(2'd1, 7'h33);
    #1 chk("busy_refuse", 64'(req_accept), 64'd0);
    step();
    chk("busy_not_pending", 64'(pending), 64'd0);
    issue(2'd1, 7'h33); dmireset = 1'b1;
    #1 chk("busy_refuse_dmireset_cycle", 64'(req_accept), 64'd0);
    step();
    chk("dmireset_clears", 64'(sticky), 64'd0);
    issue(2'd1, 7'h33);
    #1 chk("after_dmireset_accept", 64'(req_accept), 64'd1);
    step();
    respond(32'hCAFEF00D, 2'd0);
    step();

    // Timeout with a late response that must be dropped.
    issue(2'd1, 7'h44);
    step();
    tcnt = 0; tpos = 0;
    for (int i = 1; i <= 7; i++) begin
      if (i == 6) respond(32'hBAD0BAD0, 2'd0);
      step();
      if (timeout) begin tcnt++; tpos = i; end
    end
    chk("timeout_count", 64'(tcnt), 64'd1);
    chk("timeout_position", 64'(tpos), 64'd4);
    chk("timeout_sticky", 64'(sticky), 64'd2);
    capture_dr = 1'b1;
    step();
    chk("timeout_capture", 64'(dr_capture), 64'({7'h44, 32'hCAFEF00D, 2'd2}));
    dmireset = 1'b1;
    step();

    // Response on the expiry cycle wins.
    issue(2'd1, 7'h55);
    step(); step(); step(); step();
    respond(32'h0BADF00D, 2'd0);
    step();
    chk("race_timeout", 64'(timeout), 64'd0);
    chk("race_sticky", 64'(sticky), 64'd0);
    chk("race_pending", 64'(pending), 64'd0);
    capture_dr = 1'b1;
    step();
    chk("race_capture", 64'(dr_capture), 64'({7'h55, 32'h0BADF00D, 2'd0}));

    // Hard reset with capture during WAIT.
    issue(2'd2, 7'h66);
    step();
    capture_dr = 1'b1;
    step();
    chk("hard_pre_sticky", 64'(sticky), 64'd3);
    dmihardreset = 1'b1; capture_dr = 1'b1;
    step();
    chk("hard_pending", 64'(pending), 64'd0);
    chk("hard_sticky", 64'(sticky), 64'd0);
    chk("hard_capture", 64'(dr_capture), 64'({7'h66, 32'd0, 2'd0}));

    // Synchronous reset mid-WAIT.
    issue(2'd1, 7'h77);
    step();
    capture_dr = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_sticky", 64'(sticky), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_capture", 64'(dr_capture), 64'd0);
    issue(2'd2, 7'h78);
    #1 chk("rst_write_accept", 64'(req_accept), 64'd1);
    step();
    chk("rst_write_pending", 64'(pending), 64'd1);
    issue(2'd1, 7'h79);
    step();
    chk("issue_in_wait_sticky", 64'(sticky), 64'd3);
    respond(32'hA5A5A5A5, 2'd2);
    step();
    capture_dr = 1'b1;
    step();
    chk("wait_issue_capture", 64'(dr_capture), 64'({7'h78, 32'hA5A5A5A5, 2'd3}));
    dmireset = 1'b1;
    step();

    // Failed response code becomes sticky.
    issue(2'd1, 7'h0A);
    step();
    respond(32'h00000001, 2'd2);
    step();
    chk("failed_sticky", 64'(sticky), 64'd2);
    dmireset = 1'b1;
    step();

    // NOP is ignored.
    issue(2'd0, 7'h7F);
    #1 chk("nop_accept", 64'(req_accept), 64'd0);
    step();
    chk("nop_pending", 64'(pending), 64'd0);
    // Spurious response in IDLE with capture: data unchanged.
    respond(32'hFFFFFFFF, 2'd3); capture_dr = 1'b1;
    step();
    chk("spurious_capture", 64'(dr_capture), 64'({7'h0A, 32'h00000001, 2'd0}));
    step(); step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
